// File: rtl/ibex_fp_pkg.sv
// Shared encodings, types and op-class helpers for the RV32F decoder and its scoreboard.
package ibex_fp_pkg;

  localparam logic [6:0] OPC_OP_FP = 7'h53;
  localparam logic [6:0] OPC_MADD  = 7'h43;
  localparam logic [6:0] OPC_MSUB  = 7'h47;
  localparam logic [6:0] OPC_NMSUB = 7'h4B;
  localparam logic [6:0] OPC_NMADD = 7'h4F;

  localparam logic [6:0] F7_ADD    = 7'h00;
  localparam logic [6:0] F7_SUB    = 7'h04;
  localparam logic [6:0] F7_MUL    = 7'h08;
  localparam logic [6:0] F7_DIV    = 7'h0C;
  localparam logic [6:0] F7_SQRT   = 7'h2C;
  localparam logic [6:0] F7_SGNJ   = 7'h10;
  localparam logic [6:0] F7_MINMAX = 7'h14;
  localparam logic [6:0] F7_CMP    = 7'h50;
  localparam logic [6:0] F7_F2I    = 7'h60;
  localparam logic [6:0] F7_I2F    = 7'h68;
  localparam logic [6:0] F7_MV_X_W = 7'h70;
  localparam logic [6:0] F7_MV_W_X = 7'h78;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    DYN = 3'd7
  } fp_rm_e;

  typedef enum logic [5:0] {
    FPU_NOP,
    FPU_ADD,
    FPU_SUB,
    FPU_MUL,
    FPU_DIV,
    FPU_SQRT,
    FPU_SGNJ,
    FPU_SGNJ_N,
    FPU_SGNJ_X,
    FPU_MIN,
    FPU_MAX,
    FPU_CMP_EQ,
    FPU_CMP_LT,
    FPU_CMP_LE,
    FPU_FLOAT2INT,
    FPU_FLOAT2INT_U,
    FPU_INT2FLOAT,
    FPU_INT2FLOAT_U,
    FPU_MOVE_FLOAT2INT,
    FPU_FCLASS,
    FPU_MOVE_INT2FLOAT,
    FPU_MADD,
    FPU_MSUB,
    FPU_NMSUB,
    FPU_NMADD
  } fpu_op_e;

  typedef struct packed {
    fpu_op_e    op;
    logic [2:0] rm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
    logic       rs1_is_fp;
    logic       rd_is_fp;
    logic       illegal;
  } fp_cmd_t;

  function automatic logic op_uses_rm(fpu_op_e op);
    case (op)
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT,
      FPU_FLOAT2INT, FPU_FLOAT2INT_U, FPU_INT2FLOAT, FPU_INT2FLOAT_U,
      FPU_MADD, FPU_MSUB, FPU_NMSUB, FPU_NMADD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs2(fpu_op_e op);
    case (op)
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV,
      FPU_SGNJ, FPU_SGNJ_N, FPU_SGNJ_X, FPU_MIN, FPU_MAX,
      FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE,
      FPU_MADD, FPU_MSUB, FPU_NMSUB, FPU_NMADD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_rs1_is_fp(fpu_op_e op);
    case (op)
      FPU_INT2FLOAT, FPU_INT2FLOAT_U, FPU_MOVE_INT2FLOAT: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic op_rd_is_fp(fpu_op_e op);
    case (op)
      FPU_FLOAT2INT, FPU_FLOAT2INT_U, FPU_MOVE_FLOAT2INT,
      FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FPU_FCLASS: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic op_is_long(fpu_op_e op);
    return (op == FPU_DIV) || (op == FPU_SQRT);
  endfunction

  function automatic logic op_is_fma(fpu_op_e op);
    return (op == FPU_MADD) || (op == FPU_MSUB) || (op == FPU_NMSUB) || (op == FPU_NMADD);
  endfunction

endpackage

// File: rtl/ibex_fp_scoreboard.sv
// Busy bitmap and outstanding counter for DIV/SQRT results; flags hazards for the
// command sitting in the decoder output register. NUM_FREGS must be 1..32.
module ibex_fp_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned NUM_FREGS       = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_i,
  input  logic [4:0] issue_rd_i,
  input  logic       done_i,
  input  logic [4:0] done_rd_i,
  input  logic       chk_en_i,
  input  logic       chk_long_i,
  input  logic [4:0] rs1_i,
  input  logic       rs1_en_i,
  input  logic [4:0] rs2_i,
  input  logic       rs2_en_i,
  input  logic [4:0] rs3_i,
  input  logic       rs3_en_i,
  input  logic [4:0] rd_i,
  input  logic       rd_en_i,
  output logic       hazard_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_FREGS-1:0] r_busy;
  logic [NUM_FREGS-1:0] w_set;
  logic [NUM_FREGS-1:0] w_clr;
  logic [NUM_FREGS-1:0] w_busy_eff;
  logic [CntW-1:0]      r_cnt;
  logic [CntW-1:0]      w_cnt_eff;
  logic                 w_done_hit;

  function automatic logic bit_at(logic [NUM_FREGS-1:0] vec, logic [4:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FREGS; i++) begin
      if (idx == 5'(i)) hit = vec[i];
    end
    return hit;
  endfunction

  // A completion is visible in the same cycle, so a waiting command can issue at once.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < NUM_FREGS; i++) begin
      if (issue_i && (issue_rd_i == 5'(i))) w_set[i] = 1'b1;
      if (done_i && (done_rd_i == 5'(i)))   w_clr[i] = 1'b1;
    end
    w_done_hit = |(w_clr & r_busy);
    w_busy_eff = r_busy & ~w_clr;
    w_cnt_eff  = r_cnt - CntW'(w_done_hit);
  end

  always_comb begin
    hazard_o = chk_en_i && (
        (rs1_en_i && bit_at(w_busy_eff, rs1_i)) ||
        (rs2_en_i && bit_at(w_busy_eff, rs2_i)) ||
        (rs3_en_i && bit_at(w_busy_eff, rs3_i)) ||
        (rd_en_i  && bit_at(w_busy_eff, rd_i))  ||
        (chk_long_i && (w_cnt_eff == CntW'(MAX_OUTSTANDING))));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_eff | w_set;
      r_cnt  <= w_cnt_eff + CntW'(issue_i);
    end
  end

endmodule

// File: rtl/ibex_fp_decoder.sv
// RV32F decoder with output register, one-entry skid buffer and DIV/SQRT scoreboard.
// Define IBEX_FP_DEC_FMA_EN to decode the fused multiply-add opcodes.
module ibex_fp_decoder
  import ibex_fp_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned NUM_FREGS       = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [2:0]  frm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [5:0]  fpu_op_o,
  output logic [2:0]  rnd_mode_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rs3_o,
  output logic [4:0]  rd_o,
  output logic        rs1_is_fp_o,
  output logic        rd_is_fp_o,
  output logic        illegal_o,
  input  logic        long_done_i,
  input  logic [4:0]  long_done_rd_i
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rs2f;
  fpu_op_e    w_op;
  logic       w_rm_uses;
  logic       w_illegal;
  fp_cmd_t    w_dec;

  fp_cmd_t    r_out;
  fp_cmd_t    r_skid;
  logic       r_out_valid;
  logic       r_skid_valid;

  logic       w_accept;
  logic       w_out_free;
  logic       w_hazard;
  logic       w_issue_long;
  logic       w_rs3_chk;

  assign w_opc  = instr_i[6:0];
  assign w_f7   = instr_i[31:25];
  assign w_f3   = instr_i[14:12];
  assign w_rs2f = instr_i[24:20];

  always_comb begin
    w_op = FPU_NOP;
    if (w_opc == OPC_OP_FP) begin
      case (w_f7)
        F7_ADD:    w_op = FPU_ADD;
        F7_SUB:    w_op = FPU_SUB;
        F7_MUL:    w_op = FPU_MUL;
        F7_DIV:    w_op = FPU_DIV;
        F7_SQRT:   if (w_rs2f == 5'd0) w_op = FPU_SQRT;
        F7_SGNJ: begin
          case (w_f3)
            3'd0:    w_op = FPU_SGNJ;
            3'd1:    w_op = FPU_SGNJ_N;
            3'd2:    w_op = FPU_SGNJ_X;
            default: w_op = FPU_NOP;
          endcase
        end
        F7_MINMAX: begin
          case (w_f3)
            3'd0:    w_op = FPU_MIN;
            3'd1:    w_op = FPU_MAX;
            default: w_op = FPU_NOP;
          endcase
        end
        F7_CMP: begin
          case (w_f3)
            3'd2:    w_op = FPU_CMP_EQ;
            3'd1:    w_op = FPU_CMP_LT;
            3'd0:    w_op = FPU_CMP_LE;
            default: w_op = FPU_NOP;
          endcase
        end
        F7_F2I: begin
          case (w_rs2f)
            5'd0:    w_op = FPU_FLOAT2INT;
            5'd1:    w_op = FPU_FLOAT2INT_U;
            default: w_op = FPU_NOP;
          endcase
        end
        F7_I2F: begin
          case (w_rs2f)
            5'd0:    w_op = FPU_INT2FLOAT;
            5'd1:    w_op = FPU_INT2FLOAT_U;
            default: w_op = FPU_NOP;
          endcase
        end
        F7_MV_X_W: begin
          if (w_rs2f == 5'd0 && w_f3 == 3'd0)      w_op = FPU_MOVE_FLOAT2INT;
          else if (w_rs2f == 5'd0 && w_f3 == 3'd1) w_op = FPU_FCLASS;
        end
        F7_MV_W_X: if (w_rs2f == 5'd0 && w_f3 == 3'd0) w_op = FPU_MOVE_INT2FLOAT;
        default:   w_op = FPU_NOP;
      endcase
    end
`ifdef IBEX_FP_DEC_FMA_EN
    else if (instr_i[26:25] == 2'b00) begin
      case (w_opc)
        OPC_MADD:  w_op = FPU_MADD;
        OPC_MSUB:  w_op = FPU_MSUB;
        OPC_NMSUB: w_op = FPU_NMSUB;
        OPC_NMADD: w_op = FPU_NMADD;
        default:   w_op = FPU_NOP;
      endcase
    end
`endif
  end

  // Reserved static modes and a reserved dynamic frm both make an rm-using op illegal.
  always_comb begin
    w_rm_uses = op_uses_rm(w_op);
    w_illegal = (w_op == FPU_NOP) ||
                (w_rm_uses && ((w_f3 == 3'd5) || (w_f3 == 3'd6) ||
                               ((w_f3 == DYN) && (frm_i > RMM))));
    w_dec         = '0;
    w_dec.rm      = w_f3;
    w_dec.rs1     = instr_i[19:15];
    w_dec.rs2     = w_rs2f;
    w_dec.rd      = instr_i[11:7];
    w_dec.illegal = w_illegal;
    if (!w_illegal) begin
      w_dec.op        = w_op;
      w_dec.rs1_is_fp = op_rs1_is_fp(w_op);
      w_dec.rd_is_fp  = op_rd_is_fp(w_op);
      if (w_rm_uses && (w_f3 == DYN)) w_dec.rm = frm_i;
      if (op_is_fma(w_op)) w_dec.rs3 = instr_i[31:27];
    end
  end

  assign instr_ready_o = !r_skid_valid;
  assign w_accept      = instr_valid_i && instr_ready_o;
  assign out_valid_o   = r_out_valid && !w_hazard;
  assign w_out_free    = !r_out_valid || (out_valid_o && out_ready_i);
  assign w_issue_long  = out_valid_o && out_ready_i && op_is_long(r_out.op);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

`ifdef IBEX_FP_DEC_FMA_EN
  assign w_rs3_chk = op_is_fma(r_out.op);
`else
  assign w_rs3_chk = 1'b0;
`endif

  ibex_fp_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .NUM_FREGS       (NUM_FREGS)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_i    (w_issue_long),
    .issue_rd_i (r_out.rd),
    .done_i     (long_done_i),
    .done_rd_i  (long_done_rd_i),
    .chk_en_i   (!r_out.illegal),
    .chk_long_i (op_is_long(r_out.op)),
    .rs1_i      (r_out.rs1),
    .rs1_en_i   (r_out.rs1_is_fp),
    .rs2_i      (r_out.rs2),
    .rs2_en_i   (op_uses_rs2(r_out.op)),
    .rs3_i      (r_out.rs3),
    .rs3_en_i   (w_rs3_chk),
    .rd_i       (r_out.rd),
    .rd_en_i    (r_out.rd_is_fp),
    .hazard_o   (w_hazard)
  );

  assign fpu_op_o    = r_out.op;
  assign rnd_mode_o  = r_out.rm;
  assign rs1_o       = r_out.rs1;
  assign rs2_o       = r_out.rs2;
  assign rs3_o       = r_out.rs3;
  assign rd_o        = r_out.rd;
  assign rs1_is_fp_o = r_out.rs1_is_fp;
  assign rd_is_fp_o  = r_out.rd_is_fp;
  assign illegal_o   = r_out.illegal;

endmodule

// File: tb/tb_ibex_fp_decoder.sv
// Directed bench for ibex_fp_decoder: decode table plus hazard, skid and reset sequences.
module tb_ibex_fp_decoder;
  import ibex_fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  frm = '0;
  logic        out_ready = 1'b1;
  logic        long_done = 1'b0;
  logic [4:0]  long_done_rd = '0;
  logic        instr_ready, out_valid, rs1_is_fp, rd_is_fp, illegal;
  logic [5:0]  fpu_op;
  logic [2:0]  rnd_mode;
  logic [4:0]  rs1, rs2, rs3, rd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ibex_fp_decoder #(.MAX_OUTSTANDING(2), .NUM_FREGS(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_valid_i  (instr_valid),
    .instr_ready_o  (instr_ready),
    .instr_i        (instr),
    .frm_i          (frm),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .fpu_op_o       (fpu_op),
    .rnd_mode_o     (rnd_mode),
    .rs1_o          (rs1),
    .rs2_o          (rs2),
    .rs3_o          (rs3),
    .rd_o           (rd),
    .rs1_is_fp_o    (rs1_is_fp),
    .rd_is_fp_o     (rd_is_fp),
    .illegal_o      (illegal),
    .long_done_i    (long_done),
    .long_done_rd_i (long_done_rd)
  );

  typedef struct {
    string       name;
    logic [31:0] word;
    logic [2:0]  frm;
    logic        full;
    logic [5:0]  op;
    logic [2:0]  rm;
    logic [4:0]  rs1, rs2, rs3, rd;
    logic        s1fp, dfp, ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1,
                                      logic [2:0] f3, logic [4:0] d, logic [6:0] opc);
    return {f7, s2, s1, f3, d, opc};
  endfunction

  function automatic vec_t mk(string n, logic [31:0] w, logic [2:0] f, logic full,
                              logic [5:0] op, logic [2:0] rm, logic [4:0] s1, logic [4:0] s2,
                              logic [4:0] s3, logic [4:0] d, logic s1fp, logic dfp,
                              logic ill);
    vec_t v;
    v.name = n; v.word = w; v.frm = f; v.full = full; v.op = op; v.rm = rm;
    v.rs1 = s1; v.rs2 = s2; v.rs3 = s3; v.rd = d; v.s1fp = s1fp; v.dfp = dfp; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Presents a word and waits (bounded) until it is accepted.
  task automatic issue(input logic [31:0] w, input logic [2:0] f);
    int n;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = w;
    frm = f;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got instr_ready=0 expected 1 for %h", w);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 instr_valid = 1'b0;
    end
  endtask

  task automatic expect_held(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk(name, 64'(out_valid), 64'd0);
    end
  endtask

  task automatic done_pulse(input string name, input logic [4:0] r, input logic exp_valid);
    @(negedge clk);
    long_done = 1'b1;
    long_done_rd = r;
    #1 chk(name, 64'(out_valid), 64'(exp_valid));
    @(posedge clk);
    #1 long_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk("fadd", 32'h002081D3, 3'd0, 1, FPU_ADD, 3'd0, 1, 2, 0, 3, 1, 1, 0));
    vecs.push_back(mk("fsub_rtz", enc(7'h04, 6, 5, 3'd1, 4, 7'h53), 3'd0, 1, FPU_SUB, 3'd1,
                      5, 6, 0, 4, 1, 1, 0));
    vecs.push_back(mk("fmul_dyn", enc(7'h08, 12, 11, 3'd7, 10, 7'h53), 3'd4, 1, FPU_MUL, 3'd4,
                      11, 12, 0, 10, 1, 1, 0));
    vecs.push_back(mk("fsgnjx", enc(7'h10, 3, 2, 3'd2, 1, 7'h53), 3'd0, 1, FPU_SGNJ_X, 3'd2,
                      2, 3, 0, 1, 1, 1, 0));
    vecs.push_back(mk("fmax_badfrm", enc(7'h14, 3, 2, 3'd1, 1, 7'h53), 3'd6, 1, FPU_MAX, 3'd1,
                      2, 3, 0, 1, 1, 1, 0));
    vecs.push_back(mk("fle", enc(7'h50, 2, 1, 3'd0, 5, 7'h53), 3'd0, 1, FPU_CMP_LE, 3'd0,
                      1, 2, 0, 5, 1, 0, 0));
    vecs.push_back(mk("feq", enc(7'h50, 2, 1, 3'd2, 5, 7'h53), 3'd0, 1, FPU_CMP_EQ, 3'd2,
                      1, 2, 0, 5, 1, 0, 0));
    vecs.push_back(mk("fcvt_w_s", enc(7'h60, 0, 2, 3'd1, 1, 7'h53), 3'd0, 1, FPU_FLOAT2INT,
                      3'd1, 2, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("fcvt_s_wu", enc(7'h68, 1, 2, 3'd7, 1, 7'h53), 3'd3, 1, FPU_INT2FLOAT_U,
                      3'd3, 2, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk("fcvt_s_w", enc(7'h68, 0, 3, 3'd4, 2, 7'h53), 3'd0, 1, FPU_INT2FLOAT,
                      3'd4, 3, 0, 0, 2, 0, 1, 0));
    vecs.push_back(mk("fmv_x_w", enc(7'h70, 0, 2, 3'd0, 1, 7'h53), 3'd0, 1, FPU_MOVE_FLOAT2INT,
                      3'd0, 2, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("fclass", enc(7'h70, 0, 2, 3'd1, 1, 7'h53), 3'd0, 1, FPU_FCLASS, 3'd1,
                      2, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("fmv_w_x", enc(7'h78, 0, 2, 3'd0, 1, 7'h53), 3'd0, 1, FPU_MOVE_INT2FLOAT,
                      3'd0, 2, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk("addi", 32'h00000013, 3'd0, 0, FPU_NOP, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("fadd_rm5", enc(7'h00, 2, 1, 3'd5, 3, 7'h53), 3'd0, 0, FPU_NOP, 0,
                      0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("fsqrt_rs2", enc(7'h2C, 1, 5, 3'd0, 5, 7'h53), 3'd0, 0, FPU_NOP, 0,
                      0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("fdiv_rm6", enc(7'h0C, 2, 1, 3'd6, 5, 7'h53), 3'd0, 0, FPU_NOP, 0,
                      0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("fdiv_dyn_frm5", enc(7'h0C, 2, 1, 3'd7, 5, 7'h53), 3'd5, 0, FPU_NOP, 0,
                      0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("fadd_fmt_d", enc(7'h01, 2, 1, 3'd0, 3, 7'h53), 3'd0, 0, FPU_NOP, 0,
                      0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("fsgnj_f3", enc(7'h10, 2, 1, 3'd3, 3, 7'h53), 3'd0, 0, FPU_NOP, 0,
                      0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("fmv_w_x_f3", enc(7'h78, 0, 2, 3'd1, 1, 7'h53), 3'd0, 0, FPU_NOP, 0,
                      0, 0, 0, 0, 0, 0, 1));
    // f5 must not be busy after the illegal DIV/SQRT words above.
    vecs.push_back(mk("fadd_f5_free", enc(7'h00, 5, 5, 3'd0, 7, 7'h53), 3'd0, 1, FPU_ADD, 3'd0,
                      5, 5, 0, 7, 1, 1, 0));
    vecs.push_back(mk("fmadd_rm5", {5'd4, 2'b00, 5'd3, 5'd2, 3'd5, 5'd1, 7'h43}, 3'd0, 0,
                      FPU_NOP, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef IBEX_FP_DEC_FMA_EN
    vecs.push_back(mk("fmadd", {5'd4, 2'b00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h43}, 3'd0, 1, FPU_MADD,
                      3'd0, 2, 3, 4, 1, 1, 1, 0));
`else
    vecs.push_back(mk("fmadd_off", {5'd4, 2'b00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h43}, 3'd0, 0,
                      FPU_NOP, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {out_valid, instr_ready, fpu_op, illegal, rd, rnd_mode},
        {1'b0, 1'b1, 6'(FPU_NOP), 1'b0, 5'd0, 3'd0});

    foreach (vecs[i]) begin
      issue(vecs[i].word, vecs[i].frm);
      @(negedge clk);
      if (vecs[i].full)
        chk(vecs[i].name,
            {out_valid, fpu_op, rnd_mode, rs1, rs2, rs3, rd, rs1_is_fp, rd_is_fp, illegal},
            {1'b1, vecs[i].op, vecs[i].rm, vecs[i].rs1, vecs[i].rs2, vecs[i].rs3, vecs[i].rd,
             vecs[i].s1fp, vecs[i].dfp, vecs[i].ill});
      else
        chk(vecs[i].name, {out_valid, fpu_op, illegal}, {1'b1, vecs[i].op, vecs[i].ill});
    end

    // RAW on an outstanding divide result, released by its completion.
    issue(32'h1820F2D3, 3'd3);
    @(negedge clk);
    chk("fdiv_dyn", {out_valid, fpu_op, rnd_mode, rd}, {1'b1, 6'(FPU_DIV), 3'd3, 5'd5});
    issue(32'h00128353, 3'd0);
    @(negedge clk);
    chk("raw_head", {out_valid, fpu_op, rd}, {1'b0, 6'(FPU_ADD), 5'd6});
    expect_held("raw_held", 2);
    done_pulse("raw_release", 5'd5, 1'b1);
    @(negedge clk);
    chk("raw_drained", 64'(out_valid), 64'd0);

    // Outstanding limit of two long ops.
    issue(32'h182083D3, 3'd0);
    @(negedge clk);
    chk("fdiv7", {out_valid, rd}, {1'b1, 5'd7});
    issue(32'h18208453, 3'd0);
    @(negedge clk);
    chk("fdiv8", {out_valid, rd}, {1'b1, 5'd8});
    issue(32'h182084D3, 3'd0);
    @(negedge clk);
    chk("fdiv9_head", {out_valid, fpu_op, rd}, {1'b0, 6'(FPU_DIV), 5'd9});
    expect_held("fdiv9_held", 2);
    done_pulse("fdiv9_release", 5'd7, 1'b1);
    done_pulse("done_not_busy", 5'd20, 1'b0);
    issue(32'h18208553, 3'd0);
    expect_held("fdiv10_held", 3);
    done_pulse("fdiv10_release", 5'd8, 1'b1);
    done_pulse("clr9", 5'd9, 1'b0);
    done_pulse("clr10", 5'd10, 1'b0);

    // WAW on a square-root destination.
    issue(enc(7'h2C, 0, 1, 3'd0, 11, 7'h53), 3'd0);
    @(negedge clk);
    chk("fsqrt", {out_valid, fpu_op, rd}, {1'b1, 6'(FPU_SQRT), 5'd11});
    issue(enc(7'h78, 0, 2, 3'd0, 11, 7'h53), 3'd0);
    expect_held("waw_held", 3);
    done_pulse("waw_release", 5'd11, 1'b1);

    // Back-pressure: output register plus skid, then in-order drain.
    out_ready = 1'b0;
    issue(32'h002081D3, 3'd0);
    issue(enc(7'h04, 6, 5, 3'd1, 4, 7'h53), 3'd0);
    @(negedge clk);
    chk("skid_full", {instr_ready, out_valid, fpu_op}, {1'b0, 1'b1, 6'(FPU_ADD)});
    instr_valid = 1'b1;
    instr = enc(7'h08, 12, 11, 3'd0, 10, 7'h53);
    frm = 3'd0;
    @(negedge clk);
    chk("skid_stall", {instr_ready, out_valid, fpu_op}, {1'b0, 1'b1, 6'(FPU_ADD)});
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_2nd", {instr_ready, out_valid, fpu_op, rd}, {1'b1, 1'b1, 6'(FPU_SUB), 5'd4});
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("drain_3rd", {out_valid, fpu_op, rd}, {1'b1, 6'(FPU_MUL), 5'd10});
    @(negedge clk);
    chk("drain_empty", {out_valid, instr_ready}, {1'b0, 1'b1});

    // Reset with a busy register and a full skid.
    issue(32'h1820F2D3, 3'd3);
    @(negedge clk);
    chk("pre_rst_div", {out_valid, fpu_op}, {1'b1, 6'(FPU_DIV)});
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(32'h002081D3, 3'd0);
    issue(enc(7'h04, 6, 5, 3'd1, 4, 7'h53), 3'd0);
    @(negedge clk);
    chk("pre_rst_full", 64'(instr_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst", {out_valid, instr_ready, fpu_op}, {1'b0, 1'b1, 6'(FPU_NOP)});
    out_ready = 1'b1;
    issue(32'h00128353, 3'd0);
    @(negedge clk);
    chk("post_rst_f5_free", {out_valid, fpu_op, rd}, {1'b1, 6'(FPU_ADD), 5'd6});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_fp_decoder.md
Name: ibex_fp_decoder

Overview:
- Decode stage for RV32F single-precision instructions; turns 32-bit instruction words into fpu_op_e commands plus operand and rounding controls for the FPU.
- Sits between the fetch/ID pipeline and the FPU issue port, with valid/ready handshakes on both sides and a 1-cycle registered output.
- Contains a register scoreboard for long-latency ops (FPU_DIV, FPU_SQRT). It holds back dependent instructions until the FPU reports completion.

Parameters:
- MAX_OUTSTANDING, default 2: maximum number of DIV/SQRT ops in flight; range 1..8.
- NUM_FREGS, default 32: number of FP registers tracked by the scoreboard.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_valid_i  in  1  instruction word valid
- instr_ready_o  out  1  decoder can accept a word
- instr_i  in  32  instruction word
- frm_i  in  3  dynamic rounding mode from the fcsr; sampled when the word is accepted
- out_valid_o  out  1  decoded command valid
- out_ready_i  in  1  FPU accepts the command
- fpu_op_o  out  6  fpu_op_e
- rnd_mode_o  out  3  resolved rounding mode
- rs1_o, rs2_o, rs3_o, rd_o  out  5 each  register addresses
- rs1_is_fp_o  out  1  rs1 is read from the FP register file
- rd_is_fp_o  out  1  rd is written to the FP register file
- illegal_o  out  1  word is not a legal supported F instruction
- long_done_i  in  1  FPU completed a DIV/SQRT
- long_done_rd_i  in  5  rd of the completed DIV/SQRT

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - On reset, all valids, busy bits and the outstanding count clear to 0, and instr_ready_o=1.
  - Output fields reset to 0; fpu_op_o resets to FPU_NOP.
  - Reset asserted mid-operation discards the output register, the skid register and the scoreboard in that same edge.
- Buffering:
  - Structure: output register plus one skid register.
  - instr_ready_o is registered and equals !skid_valid.
  - A word accepted into an empty output register appears on out_valid_o in the next cycle, giving 1-cycle latency.
  - If the output register is stalled, the accepted word goes to the skid register.
  - When the output register drains, the skid entry moves into it.
  - Order is preserved; no word is dropped or duplicated.
- Decode, OP-FP (0x53), fmt=00 required:
  - funct7 0x00 ADD, 0x04 SUB, 0x08 MUL, 0x0C DIV.
  - 0x2C SQRT; requires rs2=0.
  - 0x10 SGNJ: funct3 0/1/2 gives SGNJ, SGNJ_N, SGNJ_X.
  - 0x14 MIN/MAX: funct3 0 MIN, 1 MAX.
  - 0x50 compare: funct3 2 CMP_EQ, 1 CMP_LT, 0 CMP_LE.
  - 0x60 float-to-int: rs2 0 FLOAT2INT, rs2 1 FLOAT2INT_U.
  - 0x68 int-to-float: rs2 0 INT2FLOAT, rs2 1 INT2FLOAT_U.
  - 0x70 with rs2=0: funct3 0 MOVE_FLOAT2INT, funct3 1 FCLASS.
  - 0x78 with rs2=0 and funct3 0: MOVE_INT2FLOAT.
  - Any other combination sets illegal_o.
- Decode, FMA opcodes (fmt=00):
  - 0x43 MADD, 0x47 MSUB, 0x4B NMSUB, 0x4F NMADD.
  - rs3 is taken from bits [31:27].
- Rounding mode:
  - Applies to ops that use rm: arithmetic, SQRT, FMA and conversions.
  - rm=111 selects the sampled frm_i.
  - rm 101 or 110 is illegal, and so is rm=111 with frm_i≥5.
  - Ops that do not use rm output rnd_mode_o=funct3.
- Operand flags:
  - rs1_is_fp_o=0 for INT2FLOAT, INT2FLOAT_U and MOVE_INT2FLOAT.
  - rd_is_fp_o=0 for FLOAT2INT(_U), MOVE_FLOAT2INT, CMP_* and FCLASS.
- Illegal words:
  - Any non-F opcode, or any illegal encoding, gives illegal_o=1 and fpu_op_o=FPU_NOP.
  - Illegal words are still forwarded and still handshake.
  - Illegal words never touch the scoreboard.
- Hazards:
  - out_valid_o = out_reg_valid && !hazard.
  - hazard is true if any of these holds:
    - rs1 is FP and busy.
    - rs2 is FP, the op uses rs2, and rs2 is busy.
    - rs3 is busy and the op is FMA.
    - rd is FP and busy.
    - The op is DIV/SQRT and count==MAX_OUTSTANDING.
  - Illegal entries never see a hazard.
- Scoreboard:
  - When out_valid_o && out_ready_i for a DIV/SQRT, set busy[rd] and increment count.
  - When long_done_i, clear busy[long_done_rd_i] and decrement count.
  - A set and a clear in the same cycle both apply, so count is unchanged.
  - long_done_i for a register that is not busy is ignored; count is unchanged.

Optional Feature:
- Macro IBEX_FP_DEC_FMA_EN.
- Defined: FMA opcodes decode as specified above.
- Undefined:
  - Opcodes 0x43, 0x47, 0x4B and 0x4F are illegal.
  - rs3_o is tied to 0.
  - The rs3 hazard term is removed.

Decomposition:
- Add to ibex_fp_pkg:
  - opcode constants for OP-FP and the four FMA opcodes;
  - funct7 constants;
  - fp_rm_e (RNE, RTZ, RDN, RUP, RMM, DYN);
  - a decoded-command struct (op, rm, rs1/rs2/rs3/rd, flags, illegal) shared by the output and skid registers.
- One sub-module, ibex_fp_scoreboard: busy bitmap, outstanding count and hazard check.

Test Plan:
- fadd.s f3,f1,f2 (0x002081D3) with out_ready_i=1: after 1 cycle, fpu_op_o=FPU_ADD, rs1=1, rs2=2, rd=3, rnd_mode_o=0, illegal_o=0.
- fdiv.s f5,f1,f2 with rm=DYN (0x1820F2D3) and frm_i=3: rnd_mode_o=3 and busy[5] set. Then fadd.s f6,f5,f1 (0x00128353) is held with out_valid_o=0 until long_done_i with rd=5, then goes valid in the same cycle.
- With MAX_OUTSTANDING=2, issue three fdiv.s to rd 7, 8 and 9: the third is held until one long_done_i.
- Hold out_ready_i=0 for 3 words: instr_ready_o drops after 2 words are buffered. Releasing out_ready_i drains all 3 in order.
- Feed word 0x00000013 (addi), rm=101 on fadd, and fsqrt with rs2≠0: each gives illegal_o=1 and fpu_op_o=FPU_NOP with no scoreboard change.
- Assert rst_i while busy[5]=1 and skid full: next cycle busy clears, out_valid_o=0 and instr_ready_o=1.
